// File: rtl/amadeus_mem_pkg.sv
// amadeus_mem_pkg: FSM states, beat sizing and job record shared by the memory-port arbiter
package amadeus_mem_pkg;
  typedef enum logic [2:0] {IDLE, ARB, RD, WR, FIN} MEM_ARB_STATE;
  localparam int JOB_ADDR_W = 32;
  localparam int JOB_LEN_W = 12;
  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction
  localparam int BEAT_BYTES = beat_bytes(128);
  typedef struct packed {
    logic [JOB_ADDR_W-1:0] addr;
    logic [JOB_LEN_W-1:0] len;
    logic write;
  } MEM_JOB;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr.
// With MEM_ARB_FIXED_PRIO_EN defined, ptr is ignored and the lowest index wins.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic [PW-1:0] w_ptr;
  logic [PW-1:0] w_idx;
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  assign w_ptr = ptr;
`endif
  // scan from the far end so the nearest requester to w_ptr overwrites last
  always_comb begin
    grant = '0;
    w_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = PW'((int'(w_ptr) + k) % N);
      if (req[w_idx]) begin
        grant = '0;
        grant[w_idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port among NUM_CH burst clients, one job at a time.
// Define MEM_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module mem_port_arbiter
  import amadeus_mem_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = JOB_ADDR_W,
  parameter int LEN_W   = JOB_LEN_W,
  parameter int MAX_OUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_start,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base_addr,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH-1:0]        ch_rready,
  input  logic [NUM_CH-1:0]        ch_wvalid,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_wack,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_write_data,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic                     mem_ready,
  input  logic [DATA_W-1:0]        mem_read_data,
  input  logic                     mem_valid,
  output logic                     err
);
  localparam int CW = $clog2(NUM_CH);
  localparam int OW = $clog2(MAX_OUT) + 1;
  localparam int BB = beat_bytes(DATA_W);
  MEM_ARB_STATE r_state, w_next;
  MEM_JOB r_job [NUM_CH];
  MEM_JOB w_job;
  logic [NUM_CH-1:0] r_busy, w_gnt;
  logic [CW-1:0] r_rr, r_g, w_gidx;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0] r_len, r_issued, r_recvd;
  logic [OW-1:0] r_out;
  logic w_free, w_rd_ld, w_wr_ld, w_ret;

  rr_arbiter #(.N(NUM_CH)) u_arb (.req(r_busy), .ptr(r_rr), .grant(w_gnt));

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_CH; i++) if (w_gnt[i]) w_gidx = CW'(i);
  end

  // the request register may be reloaded in the cycle memory takes its current content
  assign w_free  = ~(mem_read | mem_write) | mem_ready;
  assign w_rd_ld = r_state == RD && r_issued < r_len && ch_rready[r_g] && r_out != OW'(MAX_OUT) && w_free;
  assign w_wr_ld = r_state == WR && r_issued < r_len && ch_wvalid[r_g] && w_free;
  assign w_ret   = mem_valid && r_out != '0;
  assign w_job   = r_job[w_gidx];
  assign ch_busy = r_busy;
  assign ch_wack = w_wr_ld ? NUM_CH'(1) << r_g : '0;
  assign ch_done = r_state == FIN ? NUM_CH'(1) << r_g : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = |r_busy ? ARB : IDLE;
      ARB:     w_next = w_job.len == '0 ? FIN : w_job.write ? WR : RD;
      RD:      w_next = r_recvd == r_len ? FIN : RD;
      WR:      w_next = r_issued == r_len && w_free ? FIN : WR;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy <= '0;
      r_rr <= '0;
      r_g <= '0;
      r_addr <= '0;
      r_len <= '0;
      r_issued <= '0;
      r_recvd <= '0;
      r_out <= '0;
      for (int i = 0; i < NUM_CH; i++) r_job[i] <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_addr <= '0;
      mem_write_data <= '0;
      ch_rvalid <= '0;
      ch_rdata <= '0;
      err <= 1'b0;
    end else begin
      r_state <= w_next;
      for (int i = 0; i < NUM_CH; i++)
        if (ch_start[i] && !r_busy[i]) begin
          r_busy[i] <= 1'b1;
          r_job[i] <= '{addr: JOB_ADDR_W'(ch_base_addr[i*ADDR_W +: ADDR_W]),
                        len: JOB_LEN_W'(ch_len[i*LEN_W +: LEN_W]), write: ch_write[i]};
        end
      if (|(ch_start & r_busy) || (mem_valid && r_out == '0)) err <= 1'b1;
      ch_rvalid <= w_ret ? NUM_CH'(1) << r_g : '0;
      if (w_ret) ch_rdata <= mem_read_data;
      if (w_ret) r_recvd <= r_recvd + 1'b1;
      r_out <= r_out + OW'(w_rd_ld) - OW'(w_ret);
      if (w_free) begin
        mem_read <= w_rd_ld;
        mem_write <= w_wr_ld;
      end
      if (w_rd_ld || w_wr_ld) begin
        mem_addr <= r_addr;
        r_addr <= r_addr + ADDR_W'(BB);
        r_issued <= r_issued + 1'b1;
      end
      if (w_wr_ld) mem_write_data <= ch_wdata[r_g*DATA_W +: DATA_W];
      if (r_state == ARB) begin
        r_g <= w_gidx;
        r_addr <= ADDR_W'(w_job.addr);
        r_len <= LEN_W'(w_job.len);
        r_issued <= '0;
        r_recvd <= '0;
      end
      if (r_state == FIN) begin
        r_busy[r_g] <= 1'b0;
        r_rr <= r_g == CW'(NUM_CH - 1) ? '0 : r_g + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with an in-bench memory model for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int N = 3, DW = 128, AW = 32, LW = 12;
  logic clk = 0, rst = 1;
  logic [N-1:0] ch_start = '0, ch_write = '0, ch_rready = '1, ch_wvalid = '1;
  logic [N*AW-1:0] ch_base_addr = '0;
  logic [N*LW-1:0] ch_len = '0;
  logic [N*DW-1:0] ch_wdata = '0;
  logic [N-1:0] ch_wack, ch_rvalid, ch_busy, ch_done;
  logic [DW-1:0] ch_rdata, mem_write_data, mem_read_data = '0;
  logic [AW-1:0] mem_addr;
  logic mem_read, mem_write, mem_ready = 1, mem_valid = 0, err;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .ch_start(ch_start), .ch_base_addr(ch_base_addr), .ch_len(ch_len),
    .ch_write(ch_write), .ch_rready(ch_rready), .ch_wvalid(ch_wvalid), .ch_wdata(ch_wdata),
    .ch_wack(ch_wack), .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata), .ch_busy(ch_busy),
    .ch_done(ch_done), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
    .mem_read_data(mem_read_data), .mem_valid(mem_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] addr; logic wr; logic [DW-1:0] data;} req_t;
  typedef struct {int ch; logic [DW-1:0] data;} rd_t;
  typedef struct {int ch; int kind;} done_t;
  typedef struct {int t; logic [DW-1:0] data;} ret_t;
  req_t exp_req[$];
  rd_t exp_rd[$];
  done_t exp_done[$];
  ret_t rets[$];
  int n_chk = 0, n_err = 0, cyc = 0, gate = 0, stall_n = 0;
  int acc_n = 0, rv_n = 0, last_rv = 0, last_acc = 0, acc0 = 0;
  int wbeat[N], wack_n[N], post_cyc[N];

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h0001_0001};
  endfunction

  function automatic logic [DW-1:0] wpat(input int ch, input int k);
    return {32'(ch), 32'(k), 32'hFEED_BEEF, 32'(k * 7 + ch)};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // monitor the current cycle, then advance one clock and drive the memory side
  task automatic tick();
    req_t r;
    rd_t d;
    done_t e;
    ret_t q;
    #1;
    if ((mem_read || mem_write) && mem_ready) begin
      acc_n++;
      last_acc = cyc;
      if (exp_req.size() == 0) chk("req_unexp", DW'(exp_req.size()), DW'(1));
      else begin
        r = exp_req.pop_front();
        chk("mem_addr", DW'(mem_addr), DW'(r.addr));
        chk("mem_dir", DW'(mem_write), DW'(r.wr));
        if (r.wr) chk("mem_wdata", mem_write_data, r.data);
      end
      if (mem_read) rets.push_back('{t: cyc + 2, data: mdata(mem_addr)});
    end
    if ((mem_read || mem_write) && !mem_ready && exp_req.size() != 0) begin
      chk("hold_addr", DW'(mem_addr), DW'(exp_req[0].addr));
      if (mem_write) chk("hold_wdata", mem_write_data, exp_req[0].data);
    end
    if (ch_rvalid != 0) begin
      last_rv = cyc;
      rv_n++;
      if (exp_rd.size() == 0) chk("rv_unexp", DW'(exp_rd.size()), DW'(1));
      else begin
        d = exp_rd.pop_front();
        chk("rvalid", DW'(ch_rvalid), DW'(1) << d.ch);
        chk("rdata", ch_rdata, d.data);
      end
    end
    for (int i = 0; i < N; i++)
      if (ch_wack[i] === 1'b1) begin
        wbeat[i]++;
        wack_n[i]++;
      end
    if (ch_done != 0) begin
      if (exp_done.size() == 0) chk("done_unexp", DW'(exp_done.size()), DW'(1));
      else begin
        e = exp_done.pop_front();
        chk("done_ch", DW'(ch_done), DW'(1) << e.ch);
        if (e.kind == 1) chk("done_rd_lat", DW'(cyc - last_rv), DW'(1));
        if (e.kind == 2) chk("done_wr_lat", DW'(cyc - last_acc), DW'(1));
        if (e.kind == 0) chk("done_len0_lat", DW'(cyc - post_cyc[e.ch]), DW'(3));
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    mem_valid = 0;
    if (rets.size() != 0 && rets[0].t <= cyc && cyc >= gate) begin
      q = rets.pop_front();
      mem_valid = 1;
      mem_read_data = q.data;
    end
    if ((mem_read || mem_write) && stall_n > 0) begin
      mem_ready = 0;
      stall_n--;
    end else mem_ready = 1;
    for (int i = 0; i < N; i++) ch_wdata[i*DW +: DW] = wpat(i, wbeat[i]);
  endtask

  task automatic setjob(input int ch, input logic [AW-1:0] base, input int len, input logic wr);
    ch_base_addr[ch*AW +: AW] = base;
    ch_len[ch*LW +: LW] = LW'(len);
    ch_write[ch] = wr;
    ch_start[ch] = 1'b1;
    wbeat[ch] = 0;
    post_cyc[ch] = cyc;
  endtask

  task automatic expect_job(input int ch, input logic [AW-1:0] base, input int len, input logic wr);
    logic [AW-1:0] a;
    for (int k = 0; k < len; k++) begin
      a = base + AW'(k * 16);
      exp_req.push_back('{addr: a, wr: wr, data: wr ? wpat(ch, k) : '0});
      if (!wr) exp_rd.push_back('{ch: ch, data: mdata(a)});
    end
    exp_done.push_back('{ch: ch, kind: len == 0 ? 0 : wr ? 2 : 1});
  endtask

  task automatic fire();
    tick();
    ch_start = '0;
  endtask

  task automatic run(input int budget);
    for (int i = 0; i < budget && exp_done.size() != 0; i++) tick();
    tick();
    tick();
    chk("drain_done", DW'(exp_done.size()), DW'(0));
    chk("drain_rd", DW'(exp_rd.size()), DW'(0));
    chk("drain_req", DW'(exp_req.size()), DW'(0));
  endtask

  task automatic do_reset(input logic clr_rets);
    rst = 1;
    ch_start = '0;
    tick();
    tick();
    rst = 0;
    exp_req.delete();
    exp_rd.delete();
    exp_done.delete();
    if (clr_rets) rets.delete();
    gate = 0;
    stall_n = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      wbeat[i] = 0;
      wack_n[i] = 0;
      post_cyc[i] = 0;
    end
    do_reset(1);
    chk("rst_outs", DW'({ch_busy, ch_done, ch_rvalid, ch_wack, mem_read, mem_write, err}), DW'(0));
    chk("rst_addr", DW'(mem_addr), DW'(0));
    // single read burst with two-cycle memory latency
    setjob(0, 32'h1000, 3, 0);
    expect_job(0, 32'h1000, 3, 0);
    fire();
    run(100);
    chk("t1_rv_n", DW'(rv_n), DW'(3));
    chk("t1_err", DW'(err), DW'(0));
    // write burst with the first beat stalled for three cycles
    stall_n = 3;
    setjob(1, 32'h2000, 2, 1);
    expect_job(1, 32'h2000, 2, 1);
    fire();
    run(100);
    chk("t2_wack_n", DW'(wack_n[1]), DW'(2));
    // address wrap across the top of the address space
    setjob(2, 32'hFFFF_FFF0, 2, 1);
    expect_job(2, 32'hFFFF_FFF0, 2, 1);
    fire();
    run(100);
    chk("wrap_wack_n", DW'(wack_n[2]), DW'(2));
    // simultaneous posts from a freshly reset pointer, twice
    do_reset(1);
    for (int r = 0; r < 2; r++) begin
      setjob(0, 32'h3000, 1, 0);
      setjob(1, 32'h3100, 1, 1);
      setjob(2, 32'h3200, 1, 0);
      expect_job(0, 32'h3000, 1, 0);
      expect_job(1, 32'h3100, 1, 1);
      expect_job(2, 32'h3200, 1, 0);
      fire();
      run(200);
    end
    // ch0 posted after ch1 has been granted: pointer decides between ch2 and ch0
    setjob(1, 32'h3400, 1, 0);
    setjob(2, 32'h3500, 1, 0);
    expect_job(1, 32'h3400, 1, 0);
`ifdef MEM_ARB_FIXED_PRIO_EN
    expect_job(0, 32'h3600, 1, 0);
    expect_job(2, 32'h3500, 1, 0);
`else
    expect_job(2, 32'h3500, 1, 0);
    expect_job(0, 32'h3600, 1, 0);
`endif
    fire();
    tick();
    tick();
    setjob(0, 32'h3600, 1, 0);
    fire();
    run(200);
    chk("t3_err", DW'(err), DW'(0));
    // outstanding-read ceiling while memory withholds data
    acc0 = acc_n;
    setjob(0, 32'h4000, 8, 0);
    expect_job(0, 32'h4000, 8, 0);
    gate = cyc + 16;
    fire();
    repeat (12) tick();
    chk("max_out", DW'(acc_n - acc0), DW'(4));
    chk("rd_stall", DW'(mem_read), DW'(0));
    run(200);
    // zero-length job
    acc0 = acc_n;
    setjob(2, 32'h5000, 0, 0);
    expect_job(2, 32'h5000, 0, 0);
    fire();
    run(50);
    chk("len0_noacc", DW'(acc_n - acc0), DW'(0));
    // reset mid-burst, then the abandoned beats return
    setjob(0, 32'h6000, 8, 0);
    expect_job(0, 32'h6000, 8, 0);
    gate = cyc + 1000;
    fire();
    repeat (10) tick();
    do_reset(0);
    chk("rst_mid_outs", DW'({ch_busy, ch_done, ch_rvalid, mem_read, mem_write, err}), DW'(0));
    repeat (8) tick();
    chk("stray_err", DW'(err), DW'(1));
    chk("stray_drained", DW'(rets.size()), DW'(0));
    // re-post while busy
    do_reset(1);
    chk("rst_err_clr", DW'(err), DW'(0));
    setjob(0, 32'h7000, 1, 0);
    expect_job(0, 32'h7000, 1, 0);
    fire();
    setjob(0, 32'h7100, 5, 1);
    tick();
    ch_start = '0;
    chk("busy_post_err", DW'(err), DW'(1));
    run(100);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised shared memory-port controller for the accelerator's single external memory interface.
- Replaces the fixed three-client multiplexing currently inside the controller.
- NUM_CH clients (decompressor, weight buffer, compressor, future DMA) each post a burst job: base address, beat count, direction.
- The block arbitrates round-robin, generates beat addresses, tracks outstanding reads, routes return data and pulses per-channel completion.

Parameters:
- NUM_CH, 3: number of client channels (2..8).
- DATA_W, 128: memory beat width in bits; BEAT_BYTES = DATA_W/8.
- ADDR_W, 32: byte address width.
- LEN_W, 12: burst length field width in beats.
- MAX_OUT, 4: maximum outstanding read beats (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ch_start  in  NUM_CH  per-channel job post pulse.
- ch_base_addr  in  NUM_CH*ADDR_W  job base byte address; sampled with ch_start.
- ch_len  in  NUM_CH*LEN_W  job length in beats; sampled with ch_start.
- ch_write  in  NUM_CH  job direction, 1 = write; sampled with ch_start.
- ch_rready  in  NUM_CH  channel can absorb MAX_OUT more read beats.
- ch_wvalid  in  NUM_CH  write beat offered.
- ch_wdata  in  NUM_CH*DATA_W  write beat data.
- ch_wack  out  NUM_CH  write beat captured (1-cycle pulse).
- ch_rvalid  out  NUM_CH  read beat valid, one-hot.
- ch_rdata  out  DATA_W  read beat data, shared by all channels.
- ch_busy  out  NUM_CH  job pending or active.
- ch_done  out  NUM_CH  job complete (1-cycle pulse).
- mem_addr  out  ADDR_W  request address.
- mem_write_data  out  DATA_W  write data.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- mem_ready  in  1  memory accepts the current request this cycle.
- mem_read_data  in  DATA_W  returned read data; in order.
- mem_valid  in  1  read data valid.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: all outputs 0; pending jobs, counters and round-robin pointer (channel 0) cleared; FSM to IDLE.
- Job post: ch_start[i] while ch_busy[i]=0 latches base/len/dir and sets ch_busy[i] next cycle. ch_start[i] while busy is ignored and sets err.
- FSM states:
  - IDLE: go to ARB when any job is pending.
  - ARB: 1 cycle. Grant the first pending channel at or after rr_ptr. Load addr=base, issued=0, recvd=0. Go to RD, WR, or FIN when len=0.
  - RD: issue reads, then FIN once recvd==len.
  - WR: issue writes, then FIN once issued==len and the request register is empty.
  - FIN: pulse ch_done[g], clear ch_busy[g], rr_ptr=g+1 mod NUM_CH, go to IDLE.
- Memory request register:
  - mem_read/mem_write/mem_addr/mem_write_data are registered and held stable while mem_ready=0.
  - The register is freed on mem_ready=1, and may be reloaded in the same cycle.
- RD:
  - Load a request when issued<len, ch_rready[g]=1 and outstanding<MAX_OUT.
  - Each load: addr += BEAT_BYTES (wraps mod 2^ADDR_W), issued++, outstanding++.
- Read return:
  - mem_valid is registered: ch_rvalid[g] and ch_rdata appear 1 cycle after mem_valid.
  - Each return decrements outstanding and increments recvd.
  - If a return and an issue happen in the same cycle, outstanding is unchanged.
- mem_valid with outstanding=0 (including beats returned after a reset mid-burst) is dropped and sets err.
- WR: when issued<len and ch_wvalid[g]=1 and the register is free or being freed, capture ch_wdata into mem_write_data. ch_wack[g]=1 in that cycle; addr advances and issued increments.
- ch_done timing:
  - Read job: ch_done asserts 1 cycle after the last ch_rvalid.
  - Write job: ch_done asserts 1 cycle after the last write beat is accepted by memory.
  - A job with len=0 asserts ch_done 2 cycles after the grant and makes no memory access.
- Port ownership: only one job owns the port at a time; no interleaving between channels.
- Reset mid-operation: any in-flight job is abandoned, no ch_done is issued, and clients must re-post.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- When defined: ARB grants the lowest-index pending channel and rr_ptr is unused.
- When undefined: round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package amadeus_mem_pkg holds:
  - MEM_ARB_STATE enum {IDLE, ARB, RD, WR, FIN};
  - BEAT_BYTES;
  - typedef MEM_JOB struct {addr, len, write}.
- Sub-module rr_arbiter (params N): inputs req, ptr; output one-hot grant. The fixed-priority build ties ptr to 0 inside rr_arbiter.

Test Plan:
1. Ch0 read, base 0x1000, len 3, mem_ready=1, mem_valid 2 cycles after each read:
   - mem_addr 0x1000/0x1010/0x1020;
   - three ch_rvalid[0];
   - ch_done[0] 1 cycle after the last ch_rvalid;
   - err=0.
2. Ch1 write, len 2, mem_ready stalled low for 3 cycles on beat 0:
   - mem_write_data is held stable during the stall;
   - exactly 2 ch_wack[1];
   - then ch_done[1].
3. Ch0, ch1 and ch2 post in the same cycle, len 1 each:
   - grants in order 0,1,2;
   - re-posting all three yields 0,1,2 again;
   - with MEM_ARB_FIXED_PRIO_EN, ch0 wins whenever it is pending.
4. Read len 8 with memory returning nothing for 10 cycles:
   - exactly MAX_OUT=4 reads are issued, then mem_read stays 0 until data returns.
5. Job with len 0:
   - ch_done 2 cycles after the grant;
   - no mem_read or mem_write.
6. Error cases:
   - rst asserted mid-burst, then a stray mem_valid: outputs are 0 after reset and err=1;
   - ch_start while busy also sets err.
